// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings and helpers for the memory-access / writeback stage.
// Load and store funct3 values overlap by design; the opcode picks the meaning.
package mem_wb_stage_pkg;

    localparam logic [3:0] IO_REGION_DEF = 4'h8;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_CSR  = 2'b11
    } wb_sel_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_IO_WAIT = 1'b1
    } io_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] store_data;
        logic [31:0] pc;
        logic [31:0] csr;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [1:0]  wb_sel;
    } m_reg_t;

    typedef struct packed {
        logic        valid;
        logic        is_io;
        logic        misaligned;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] csr;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        reg_write;
        logic [1:0]  wb_sel;
    } w_reg_t;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Picks the addressed byte/half lane of a raw load word and sign- or
// zero-extends it to 32 bits.
module load_extend
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr_lo)
            2'd0:    lane_b = raw[7:0];
            2'd1:    lane_b = raw[15:8];
            2'd2:    lane_b = raw[23:16];
            default: lane_b = raw[31:24];
        endcase
        lane_h = addr_lo[1] ? raw[31:16] : raw[15:0];
    end

    always_comb begin
        case (funct3)
            F3_LB:   data = {{24{lane_b[7]}}, lane_b};
            F3_LH:   data = {{16{lane_h[15]}}, lane_h};
            F3_LBU:  data = {24'd0, lane_b};
            F3_LHU:  data = {16'd0, lane_h};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// M (access) and W (writeback) pipeline registers after EX. IO-region
// accesses hold M and stall upstream until the device acknowledges.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int         DWIDTH      = 32,
    parameter int         DMEM_AWIDTH = 14,
    parameter logic [3:0] IO_REGION   = IO_REGION_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_valid,
    input  logic [DWIDTH-1:0]      ex_alu_out,
    input  logic [DWIDTH-1:0]      ex_store_data,
    input  logic [DWIDTH-1:0]      ex_pc,
    input  logic [DWIDTH-1:0]      ex_csr_data,
    input  logic [4:0]             ex_rd,
    input  logic [2:0]             ex_funct3,
    input  logic                   ex_mem_read,
    input  logic                   ex_mem_write,
    input  logic                   ex_reg_write,
    input  logic [1:0]             ex_wb_sel,
    output logic [DMEM_AWIDTH-1:0] dmem_addr,
    output logic [3:0]             dmem_we,
    output logic [DWIDTH-1:0]      dmem_din,
    input  logic [DWIDTH-1:0]      dmem_dout,
    output logic                   io_req,
    output logic                   io_we,
    output logic [DWIDTH-1:0]      io_addr,
    output logic [DWIDTH-1:0]      io_wdata,
    output logic [3:0]             io_be,
    input  logic                   io_ack,
    input  logic [DWIDTH-1:0]      io_rdata,
    output logic                   stall_out,
    output logic                   wb_we,
    output logic [4:0]             wb_rd,
    output logic [DWIDTH-1:0]      wb_data,
    output logic                   misalign_err
);

    io_state_e   state_q, state_d;
    m_reg_t      m_q, m_d;
    w_reg_t      w_q, w_d;
    logic [31:0] io_rdata_q, io_rdata_d;

    logic        in_wait;
    logic        m_is_io;
    logic        m_misaligned;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic        ex_io_start;
    logic [31:0] load_raw;
    logic [31:0] load_data;

    assign in_wait   = (state_q == ST_IO_WAIT);
    assign stall_out = in_wait;

    always_comb begin
        m_is_io      = (m_q.addr[31:28] == IO_REGION);
        m_misaligned = (m_q.mem_read | m_q.mem_write) &
                       is_misaligned(m_q.funct3, m_q.addr[1:0]);
        m_be         = byte_en(m_q.funct3, m_q.addr[1:0]);
        case (m_q.funct3[1:0])
            2'b00:   m_wdata = {4{m_q.store_data[7:0]}};
            2'b01:   m_wdata = {2{m_q.store_data[15:0]}};
            default: m_wdata = m_q.store_data;
        endcase
    end

    // Decided from EX so the FSM enters IO_WAIT on the same edge M captures it.
    assign ex_io_start = ex_valid & (ex_mem_read | ex_mem_write) &
                         (ex_alu_out[31:28] == IO_REGION) &
                         !is_misaligned(ex_funct3, ex_alu_out[1:0]);

    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        io_rdata_d = io_rdata_q;
        if (!in_wait) begin
            m_d.valid      = ex_valid;
            m_d.addr       = ex_alu_out;
            m_d.store_data = ex_store_data;
            m_d.pc         = ex_pc;
            m_d.csr        = ex_csr_data;
            m_d.rd         = ex_rd;
            m_d.funct3     = ex_funct3;
            m_d.mem_read   = ex_mem_read;
            m_d.mem_write  = ex_mem_write;
            m_d.reg_write  = ex_reg_write;
            m_d.wb_sel     = ex_wb_sel;
            if (ex_io_start) state_d = ST_IO_WAIT;
        end else if (io_ack) begin
            state_d    = ST_IDLE;
            io_rdata_d = io_rdata;
            // EX is still held on this edge; the finished op must not be replayed.
            m_d.valid  = 1'b0;
        end
    end

    always_comb begin
        w_d = w_q;
        if (!in_wait || io_ack) begin
            w_d.valid      = m_q.valid;
            w_d.is_io      = m_is_io;
            w_d.misaligned = m_misaligned;
            w_d.alu        = m_q.addr;
            w_d.pc         = m_q.pc;
            w_d.csr        = m_q.csr;
            w_d.rd         = m_q.rd;
            w_d.funct3     = m_q.funct3;
            w_d.reg_write  = m_q.reg_write;
            w_d.wb_sel     = m_q.wb_sel;
        end else begin
            w_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            m_q        <= '0;
            w_q        <= '0;
            io_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            w_q        <= w_d;
            io_rdata_q <= io_rdata_d;
        end
    end

    assign dmem_addr = m_q.addr[DMEM_AWIDTH+1:2];
    assign dmem_din  = m_wdata;
    assign dmem_we   = (m_q.valid & m_q.mem_write & !m_is_io & !m_misaligned) ? m_be : 4'b0000;

    assign io_req   = in_wait;
    assign io_we    = in_wait & m_q.mem_write;
    assign io_addr  = in_wait ? m_q.addr : '0;
    assign io_wdata = in_wait ? m_wdata : '0;
    assign io_be    = in_wait ? m_be : 4'b0000;

    assign load_raw = w_q.is_io ? io_rdata_q : dmem_dout;

    load_extend u_load_extend (
        .funct3  (w_q.funct3),
        .addr_lo (w_q.alu[1:0]),
        .raw     (load_raw),
        .data    (load_data)
    );

    always_comb begin
        case (w_q.wb_sel)
            WB_ALU:  wb_data = w_q.alu;
            WB_LOAD: wb_data = load_data;
            WB_PC4:  wb_data = w_q.pc + 32'd4;
            default: wb_data = w_q.csr;
        endcase
    end

    assign wb_we        = w_q.valid & w_q.reg_write & !w_q.misaligned & (w_q.rd != 5'd0);
    assign wb_rd        = w_q.rd;
    assign misalign_err = w_q.valid & w_q.misaligned;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed and randomized bench for mem_wb_stage against a byte-addressed
// memory / IO reference model with an in-order writeback scoreboard.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [31:0] ex_alu_out, ex_store_data, ex_pc, ex_csr_data;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_wb_sel;
    logic [13:0] dmem_addr;
    logic [3:0]  dmem_we, io_be;
    logic [31:0] dmem_din, dmem_dout, io_addr, io_wdata, io_rdata, wb_data;
    logic        io_req, io_we, io_ack, stall_out, wb_we, misalign_err;
    logic [4:0]  wb_rd;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_csr_data(ex_csr_data),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_wb_sel(ex_wb_sel),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_din(dmem_din), .dmem_dout(dmem_dout),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_be(io_be),
        .io_ack(io_ack), .io_rdata(io_rdata), .stall_out(stall_out), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_data(wb_data), .misalign_err(misalign_err)
    );

    // Synchronous data RAM seen by the DUT
    logic [31:0] ram [0:16383];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (dmem_we[i]) ram[dmem_addr][8*i +: 8] <= dmem_din[8*i +: 8];
        dmem_dout <= ram[dmem_addr];
    end

    typedef struct {
        logic        valid;
        logic [31:0] alu, sd, pc, csr;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        mr, mw, rw;
        logic [1:0]  sel;
    } ins_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wlanes; logic [31:0] rdata; } io_t;

    logic [7:0]  mmem [0:65535];
    wb_t         exp_q[$];
    io_t         io_q[$];
    int          exp_mis = 0, got_mis = 0;
    int          n_checks = 0, n_errors = 0;
    logic [31:0] io_next_rdata = 32'h0;
    bit          io_manual = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one instruction, applied in program order.
    task automatic model(input ins_t t);
        logic        io;
        int          sz, base, lane;
        logic        mis;
        logic [31:0] ld, tmp;
        io_t         x;
        wb_t         w;
        if (!t.valid) return;
        io   = (t.alu[31:28] == 4'h8);
        sz   = (t.f3[1:0] == 2'b00) ? 1 : (t.f3[1:0] == 2'b01) ? 2 : 4;
        mis  = (t.mr || t.mw) && (t.alu % sz != 0);
        base = int'(t.alu[15:0]);
        ld   = 32'h0;
        if (mis) begin
            exp_mis++;
            return;
        end
        if (t.mr || t.mw) begin
            if (io) begin
                x.addr = t.alu; x.we = t.mw; x.rdata = io_next_rdata;
                x.be = 4'b0; x.wlanes = 32'h0;
                for (int i = 0; i < sz; i++) begin
                    lane = (int'(t.alu[1:0]) + i) % 4;
                    x.be[lane] = 1'b1;
                    tmp = (t.sd >> (8*i)) & 32'hFF;
                    x.wlanes |= tmp << (8*lane);
                    tmp = x.rdata >> (8*lane);
                    ld |= (tmp & 32'hFF) << (8*i);
                end
                io_q.push_back(x);
            end else begin
                for (int i = 0; i < sz; i++) begin
                    if (t.mw) begin
                        tmp = t.sd >> (8*i);
                        mmem[(base + i) % 65536] = tmp[7:0];
                    end
                    ld |= 32'(mmem[(base + i) % 65536]) << (8*i);
                end
            end
            if (!t.f3[2] && sz == 1 && ld[7])  ld |= 32'hFFFFFF00;
            if (!t.f3[2] && sz == 2 && ld[15]) ld |= 32'hFFFF0000;
        end
        if (t.rw && t.rd != 5'd0) begin
            w.rd = t.rd;
            case (t.sel)
                2'b00:   w.data = t.alu;
                2'b01:   w.data = ld;
                2'b10:   w.data = t.pc + 32'd4;
                default: w.data = t.csr;
            endcase
            exp_q.push_back(w);
        end
    endtask

    function automatic ins_t mk(input logic [31:0] alu, input logic [2:0] f3, input logic mr,
                                input logic mw, input logic [4:0] rd, input logic [1:0] sel);
        ins_t t;
        t.valid = 1'b1; t.alu = alu; t.sd = 32'h0; t.pc = 32'h0; t.csr = 32'h0;
        t.rd = rd; t.f3 = f3; t.mr = mr; t.mw = mw; t.rw = !mw; t.sel = sel;
        return t;
    endfunction

    task automatic drive(input ins_t t);
        ex_valid = t.valid; ex_alu_out = t.alu; ex_store_data = t.sd; ex_pc = t.pc;
        ex_csr_data = t.csr; ex_rd = t.rd; ex_funct3 = t.f3; ex_mem_read = t.mr;
        ex_mem_write = t.mw; ex_reg_write = t.rw; ex_wb_sel = t.sel;
    endtask

    // Present an instruction and wait (bounded) for M to capture it.
    task automatic send(input ins_t t);
        logic st;
        int   guard;
        drive(t);
        guard = 0;
        do begin
            @(negedge clk); st = stall_out;
            @(posedge clk); #1;
            guard++;
        end while (st && guard < 200);
        chk("capture", 32'(st), 32'd0);
        if (!st) model(t);
    endtask

    task automatic bubble();
        ins_t t;
        t = mk(32'h0, 3'b0, 1'b0, 1'b0, 5'd0, 2'b00);
        t.valid = 1'b0; t.rw = 1'b0;
        send(t);
    endtask

    // Writeback scoreboard and misalign pulse counter
    always @(negedge clk) begin
        if (rst_n) begin
            if (misalign_err) got_mis++;
            if (wb_we) begin
                if (exp_q.size() == 0) chk("wb_unexpected", 32'(wb_we), 32'd0);
                else begin
                    chk("wb_rd", 32'(wb_rd), 32'(exp_q[0].rd));
                    chk("wb_data", wb_data, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Auto-responding IO device with random acknowledge delay
    initial begin
        io_t x;
        io_ack = 1'b0; io_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!io_manual && rst_n && io_req) begin
                if (io_q.size() == 0) begin
                    chk("io_unexpected", 32'(io_req), 32'd0);
                    x.rdata = 32'h0;
                end else begin
                    x = io_q.pop_front();
                    chk("io_addr", io_addr, x.addr);
                    chk("io_we", 32'(io_we), 32'(x.we));
                    if (x.we) begin
                        chk("io_be", 32'(io_be), 32'(x.be));
                        chk("io_wdata", io_wdata & {{8{x.be[3]}}, {8{x.be[2]}}, {8{x.be[1]}}, {8{x.be[0]}}}, x.wlanes);
                    end
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                io_rdata = x.rdata; io_ack = 1'b1;
                @(negedge clk);
                io_ack = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ins_t t;
        int   kind, szk;
        for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
        for (int i = 0; i < 65536; i++) mmem[i] = 8'h0;
        t = mk(32'h0, 3'b0, 1'b0, 1'b0, 5'd0, 2'b00); t.valid = 1'b0; t.rw = 1'b0;
        drive(t);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_io_req", 32'(io_req), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_mis", 32'(misalign_err), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_io_addr", io_addr, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        t = mk(32'h100, F3_SW, 1'b0, 1'b1, 5'd0, 2'b00); t.sd = 32'hDEADBEEF; send(t);
        chk("sw_we", 32'(dmem_we), 32'hF);
        chk("sw_addr", 32'(dmem_addr), 32'h40);
        send(mk(32'h103, F3_LB, 1'b1, 1'b0, 5'd1, 2'b01));
        bubble();
        chk("lb_lat_we", 32'(wb_we), 32'd1);
        chk("lb_data", wb_data, 32'hFFFFFFDE);
        send(mk(32'h103, F3_LBU, 1'b1, 1'b0, 5'd2, 2'b01));
        t = mk(32'h102, F3_SH, 1'b0, 1'b1, 5'd0, 2'b00); t.sd = 32'h00001234; send(t);
        chk("sh_we", 32'(dmem_we), 32'hC);
        chk("sh_din", dmem_din, 32'h12341234);
        send(mk(32'h102, F3_LH, 1'b1, 1'b0, 5'd3, 2'b01));
        t = mk(32'h101, F3_SW, 1'b0, 1'b1, 5'd0, 2'b00); t.sd = 32'h55555555; send(t);
        chk("mis_we", 32'(dmem_we), 32'd0);
        bubble();
        chk("mis_pulse", 32'(misalign_err), 32'd1);
        chk("mis_wb_we", 32'(wb_we), 32'd0);
        bubble();
        chk("mis_pulse_end", 32'(misalign_err), 32'd0);
        t = mk(32'h0, 3'b0, 1'b0, 1'b0, 5'd5, 2'b10); t.pc = 32'hFFFFFFFC; send(t);
        bubble();
        chk("pc4_wrap", wb_data, 32'h0);
        send(mk(32'h55, 3'b0, 1'b0, 1'b0, 5'd0, 2'b00));
        bubble();
        chk("rd0_we", 32'(wb_we), 32'd0);

        // Stray io_ack while idle must be ignored
        io_ack = 1'b1;
        send(mk(32'h100, F3_LW, 1'b1, 1'b0, 5'd6, 2'b01));
        io_ack = 1'b0;
        chk("idle_ack_stall", 32'(stall_out), 32'd0);
        bubble();

        // IO load, acknowledged on the third wait cycle
        io_next_rdata = 32'hCAFEF00D;
        send(mk(32'h80000010, F3_LW, 1'b1, 1'b0, 5'd7, 2'b01));
        ex_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("io_wait_req", 32'(io_req), 32'd1);
            chk("io_wait_stall", 32'(stall_out), 32'd1);
            chk("io_wait_mhold", 32'(dmem_addr), 32'h4);
            if (k == 2) begin
                io_rdata = 32'hCAFEF00D; io_ack = 1'b1;
                void'(io_q.pop_front());
            end
        end
        @(posedge clk); #1;
        io_ack = 1'b0;
        chk("io_done_stall", 32'(stall_out), 32'd0);
        chk("io_done_we", 32'(wb_we), 32'd1);
        chk("io_done_data", wb_data, 32'hCAFEF00D);
        bubble();
        io_manual = 1'b0;

        repeat (400) begin
            kind = $urandom_range(0, 9);
            szk  = $urandom_range(0, 2);
            t = mk($urandom_range(0, 1023), 3'(szk), 1'b0, 1'b0, 5'($urandom_range(0, 31)), 2'b00);
            if ($urandom_range(0, 6) == 0) t.alu = 32'h80000000 | ($urandom & 32'hFF);
            t.sd = $urandom; t.pc = $urandom; t.csr = $urandom;
            io_next_rdata = $urandom;
            if (kind == 0) begin
                t.valid = 1'b0;
            end else if (kind <= 3) begin
                t.mr = 1'b1; t.sel = 2'b01;
                if (szk < 2 && $urandom_range(0, 1) == 1) t.f3[2] = 1'b1;
            end else if (kind <= 6) begin
                t.mw = 1'b1; t.rw = 1'b0;
            end else begin
                t.alu = $urandom;
                t.sel = ($urandom_range(0, 2) == 0) ? 2'b00 : ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
            end
            send(t);
        end
        repeat (4) bubble();
        chk("drain_wb", 32'(exp_q.size()), 32'd0);
        chk("drain_io", 32'(io_q.size()), 32'd0);
        chk("mis_count", 32'(got_mis), 32'(exp_mis));

        // Reset in the middle of an IO wait abandons the access
        io_manual = 1'b1;
        send(mk(32'h80000020, F3_LW, 1'b1, 1'b0, 5'd9, 2'b01));
        ex_valid = 1'b0;
        @(negedge clk);
        chk("abort_req_before", 32'(io_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_req", 32'(io_req), 32'd0);
        chk("abort_stall", 32'(stall_out), 32'd0);
        exp_q.delete();
        io_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_wb", 32'(wb_we), 32'd0);
        chk("abort_idle", 32'(stall_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
